// File: rtl/dma_arb_pkg.sv
// =============================================================================
// Module   : dma_arb_pkg
// Brief    : Shared types, defaults and helpers for the DMA arbiter.
// Revision : 1.0
// =============================================================================
`default_nettype none

package dma_arb_pkg;

  localparam int unsigned DEF_NUM_DEV  = 4;
  localparam int unsigned DEF_ADD_LEN  = 16;
  localparam int unsigned DEF_DATA_LEN = 16;
  localparam int unsigned DEF_SETTLE   = 2;

  // Index width, never below one bit so single-entry vectors stay legal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

`ifdef SIM
  typedef enum logic [87:0] {
    S_SETTLE  = "SETTLE_WAIT",
    S_IDLE    = "IDLE       ",
    S_ARB     = "ARB        ",
    S_ISSUE   = "ISSUE      ",
    S_BUSY    = "BUSY       ",
    S_RELEASE = "RELEASE    "
  } arb_state_e;
`else
  typedef enum logic [2:0] {
    S_SETTLE  = 3'd0,
    S_IDLE    = 3'd1,
    S_ARB     = 3'd2,
    S_ISSUE   = 3'd3,
    S_BUSY    = 3'd4,
    S_RELEASE = 3'd5
  } arb_state_e;
`endif

endpackage

`default_nettype wire

// File: rtl/dma_arbiter_rr_pick.sv
// =============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker scanning from last+1.
//            DMA_ARB_PRIO_EN: request 0 overrides the rotation.
// Revision : 1.0
// =============================================================================
`default_nettype none

module rr_pick
  import dma_arb_pkg::*;
#(
  parameter int unsigned N  = DEF_NUM_DEV,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW:0] cand;
  logic        found;

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = {1'b0, last_i} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!found && req_i[cand[IW-1:0]]) begin
        idx_o = cand[IW-1:0];
        found = 1'b1;
      end
    end
`ifdef DMA_ARB_PRIO_EN
    if (req_i[0]) begin
      idx_o = '0;
    end
`endif
  end

  assign valid_o  = |req_i;
  assign onehot_o = valid_o ? (N'(1) << idx_o) : '0;

endmodule

`default_nettype wire

// File: rtl/dma_arbiter.sv
// =============================================================================
// Module   : dma_arbiter
// Brief    : Round-robin sharing of one DMA controller among NUM_DEV devices.
//            DMA_ARB_PRIO_EN: device 0 gets fixed top priority.
// Revision : 1.0
// =============================================================================
`default_nettype none

module dma_arbiter
  import dma_arb_pkg::*;
#(
  parameter int unsigned NUM_DEV  = DEF_NUM_DEV,
  parameter int unsigned ADD_LEN  = DEF_ADD_LEN,
  parameter int unsigned DATA_LEN = DEF_DATA_LEN,
  parameter int unsigned SETTLE   = DEF_SETTLE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_DEV-1:0]            dev_rqst,
  input  logic [NUM_DEV-1:0]            dev_rd_wr,
  input  logic [NUM_DEV*ADD_LEN-1:0]    dev_num_words,
  input  logic [NUM_DEV*(ADD_LEN+1)-1:0] dev_start_addr,
  input  logic [NUM_DEV-1:0]            dev_ack_in,
  input  logic [NUM_DEV*DATA_LEN-1:0]   dev_data_in,
  output logic [NUM_DEV-1:0]            dev_grant,
  output logic [NUM_DEV-1:0]            dev_dma_ack,
  output logic [NUM_DEV-1:0]            dev_end,
  output logic [DATA_LEN-1:0]           dev_data_out,
  output logic                          rqst,
  output logic                          rd_wr,
  output logic [ADD_LEN-1:0]            num_words,
  output logic [ADD_LEN:0]              start_addr,
  output logic                          dev_ack,
  output logic [DATA_LEN-1:0]           dev_in,
  input  logic                          dma_ack,
  input  logic                          end_flag,
  input  logic [DATA_LEN-1:0]           dev_out
);

  localparam int unsigned IW          = idx_w(NUM_DEV);
  localparam int unsigned CW          = idx_w(SETTLE + 1);
  localparam int unsigned SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

  arb_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       last_q, last_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [NUM_DEV-1:0]  grant_q, grant_d;
  logic                rd_wr_q, rd_wr_d;
  logic [ADD_LEN-1:0]  nw_q, nw_d;
  logic [ADD_LEN:0]    sa_q, sa_d;

  logic [NUM_DEV-1:0]  pick_onehot;
  logic [IW-1:0]       pick_idx;
  logic                pick_valid;

  logic [ADD_LEN-1:0]  nw_arr   [NUM_DEV];
  logic [ADD_LEN:0]    sa_arr   [NUM_DEV];
  logic [DATA_LEN-1:0] data_arr [NUM_DEV];

  for (genvar i = 0; i < NUM_DEV; i++) begin : g_unpack
    assign nw_arr[i]   = dev_num_words[i*ADD_LEN +: ADD_LEN];
    assign sa_arr[i]   = dev_start_addr[i*(ADD_LEN+1) +: ADD_LEN+1];
    assign data_arr[i] = dev_data_in[i*DATA_LEN +: DATA_LEN];
  end

  rr_pick #(
    .N  (NUM_DEV),
    .IW (IW)
  ) u_pick (
    .req_i    (dev_rqst),
    .last_i   (last_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SETTLE;
      cnt_q   <= '0;
      last_q  <= IW'(NUM_DEV - 1);
      gidx_q  <= '0;
      grant_q <= '0;
      rd_wr_q <= 1'b0;
      nw_q    <= '0;
      sa_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      rd_wr_q <= rd_wr_d;
      nw_q    <= nw_d;
      sa_q    <= sa_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    gidx_d      = gidx_q;
    grant_d     = grant_q;
    rd_wr_d     = rd_wr_q;
    nw_d        = nw_q;
    sa_d        = sa_q;
    rqst        = 1'b0;
    dev_ack     = 1'b0;
    dev_in      = '0;
    dev_dma_ack = '0;
    dev_end     = '0;
    case (state_q)
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE_LAST)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_IDLE: begin
        if (|dev_rqst) begin
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        // A request withdrawn before arbitration simply falls back to IDLE.
        if (pick_valid) begin
          gidx_d  = pick_idx;
          grant_d = pick_onehot;
          rd_wr_d = dev_rd_wr[pick_idx];
          nw_d    = nw_arr[pick_idx];
          sa_d    = sa_arr[pick_idx];
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        rqst    = 1'b1;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        dev_ack             = dev_ack_in[gidx_q];
        dev_in              = data_arr[gidx_q];
        dev_dma_ack[gidx_q] = dma_ack;
        dev_end[gidx_q]     = end_flag;
        if (end_flag) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        last_d  = gidx_q;
        grant_d = '0;
        rd_wr_d = 1'b0;
        nw_d    = '0;
        sa_d    = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_SETTLE;
      end
    endcase
  end

  assign dev_grant    = grant_q;
  assign rd_wr        = rd_wr_q;
  assign num_words    = nw_q;
  assign start_addr   = sa_q;
  assign dev_data_out = dev_out;

endmodule

`default_nettype wire
